// File: rtl/gsm_pkg.sv
// Shared constants, FSM state type and helpers for the grouped-share-memory common write bus.
package gsm_pkg;

    localparam int MWIDTH     = 4;
    localparam int LOG_MWIDTH = 2;
    localparam int AWIDTH     = 7;
    localparam int CELL_BEATS = 4;
    localparam int LOG_BEATS  = 2;

    // A port owns 2**AWIDTH cells, so the counter needs one extra bit to hold "all free".
    localparam logic [AWIDTH:0] CREDIT_FULL = {1'b1, {AWIDTH{1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } gsm_state_e;

    function automatic logic [LOG_MWIDTH-1:0] onehot_to_bin(input logic [MWIDTH-1:0] oh);
        logic [LOG_MWIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < MWIDTH; i++) begin
            if (oh[i]) b = b | LOG_MWIDTH'(i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gsm_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after the pointer, wrapping.
module gsm_rr_arbiter
    import gsm_pkg::*;
(
    input  logic [MWIDTH-1:0]     elig,
    input  logic [LOG_MWIDTH-1:0] ptr,
    output logic [MWIDTH-1:0]     win_oh,
    output logic [LOG_MWIDTH-1:0] win_id,
    output logic                  any_valid
);

    always_comb begin : pick
        logic found;
        int   idx;
        win_oh = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < MWIDTH; i++) begin
            idx = (int'(ptr) + i) % MWIDTH;
            if (!found && elig[idx]) begin
                win_oh[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign win_id    = onehot_to_bin(win_oh);
    assign any_valid = |elig;

endmodule

// File: rtl/gsm_bus_sched.sv
// Common write-bus scheduler: round-robin cell grants, one-hot bus select and per-port credit tracking.
module gsm_bus_sched
    import gsm_pkg::*;
(
    input  logic                  clk_320M,
    input  logic                  rst,
    input  logic                  clr_320M,
    input  logic [MWIDTH-1:0]     i_req,
    input  logic [MWIDTH-1:0]     i_buf_free,
    output logic [MWIDTH-1:0]     o_grant,
    output logic [MWIDTH-1:0]     o_common_sel,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic [LOG_MWIDTH-1:0] o_grant_id,
    output logic [MWIDTH-1:0]     o_credit_avail,
    output logic                  o_credit_err,
    output gsm_state_e            o_fsm_state
);

    gsm_state_e            state;
    logic [LOG_MWIDTH-1:0] ptr;
    logic [LOG_BEATS-1:0]  beat;
    logic [LOG_BEATS-1:0]  beat_nxt;
    logic [AWIDTH:0]       credit [MWIDTH];
    logic [MWIDTH-1:0]     elig;
    logic [MWIDTH-1:0]     win_oh;
    logic [LOG_MWIDTH-1:0] win_id;
    logic                  any_valid;
    logic                  start;

    // A grant pulse has not yet been taken off the counter, so a port at one
    // credit that is being granted this cycle must not win again.
    always_comb begin
        elig           = '0;
        o_credit_avail = '0;
        for (int k = 0; k < MWIDTH; k++) begin
            o_credit_avail[k] = (credit[k] != '0);
            elig[k] = i_req[k] && (credit[k] != '0) &&
                      !(o_grant[k] && (credit[k] == (AWIDTH+1)'(1)));
        end
    end

    gsm_rr_arbiter u_arb (
        .elig      (elig),
        .ptr       (ptr),
        .win_oh    (win_oh),
        .win_id    (win_id),
        .any_valid (any_valid)
    );

    assign start       = any_valid && ((state == IDLE) || o_eop);
    assign beat_nxt    = beat + 1'b1;
    assign o_fsm_state = state;

    always_ff @(posedge clk_320M or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            beat         <= '0;
            o_grant      <= '0;
            o_common_sel <= '0;
            o_sop        <= 1'b0;
            o_eop        <= 1'b0;
            o_grant_id   <= '0;
        end else if (clr_320M) begin
            state        <= IDLE;
            ptr          <= '0;
            beat         <= '0;
            o_grant      <= '0;
            o_common_sel <= '0;
            o_sop        <= 1'b0;
            o_eop        <= 1'b0;
            o_grant_id   <= '0;
        end else if (start) begin
            state        <= XFER;
            ptr          <= (win_id == LOG_MWIDTH'(MWIDTH-1)) ? '0 : win_id + 1'b1;
            beat         <= '0;
            o_grant      <= win_oh;
            o_common_sel <= win_oh;
            o_sop        <= 1'b1;
            o_eop        <= (CELL_BEATS == 1);
            o_grant_id   <= win_id;
        end else if ((state == XFER) && o_eop) begin
            state        <= IDLE;
            beat         <= '0;
            o_grant      <= '0;
            o_common_sel <= '0;
            o_sop        <= 1'b0;
            o_eop        <= 1'b0;
            o_grant_id   <= '0;
        end else if (state == XFER) begin
            beat         <= beat_nxt;
            o_grant      <= '0;
            o_sop        <= 1'b0;
            o_eop        <= (beat_nxt == LOG_BEATS'(CELL_BEATS-1));
        end else begin
            o_grant      <= '0;
            o_sop        <= 1'b0;
        end
    end

    always_ff @(posedge clk_320M or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MWIDTH; k++) credit[k] <= CREDIT_FULL;
            o_credit_err <= 1'b0;
        end else if (clr_320M) begin
            for (int k = 0; k < MWIDTH; k++) credit[k] <= CREDIT_FULL;
            o_credit_err <= 1'b0;
        end else begin
            for (int k = 0; k < MWIDTH; k++) begin
                case ({o_grant[k], i_buf_free[k]})
                    2'b01: begin
                        if (credit[k] == CREDIT_FULL) o_credit_err <= 1'b1;
                        else                          credit[k]    <= credit[k] + 1'b1;
                    end
                    2'b10:   credit[k] <= credit[k] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gsm_bus_sched.sv
// Bench for gsm_bus_sched: grant-order scoreboard, credit model and directed cell-timing checks.
module tb_gsm_bus_sched;
    import gsm_pkg::*;

    localparam int W = MWIDTH;

    logic                  clk_320M = 1'b0;
    logic                  rst = 1'b1;
    logic                  clr_320M = 1'b0;
    logic [W-1:0]          i_req = '0;
    logic [W-1:0]          i_buf_free = '0;
    logic [W-1:0]          o_grant;
    logic [W-1:0]          o_common_sel;
    logic                  o_sop;
    logic                  o_eop;
    logic [LOG_MWIDTH-1:0] o_grant_id;
    logic [W-1:0]          o_credit_avail;
    logic                  o_credit_err;
    gsm_state_e            o_fsm_state;

    // clock / reset
    always #5 clk_320M = ~clk_320M;

    gsm_bus_sched dut (
        .clk_320M       (clk_320M),
        .rst            (rst),
        .clr_320M       (clr_320M),
        .i_req          (i_req),
        .i_buf_free     (i_buf_free),
        .o_grant        (o_grant),
        .o_common_sel   (o_common_sel),
        .o_sop          (o_sop),
        .o_eop          (o_eop),
        .o_grant_id     (o_grant_id),
        .o_credit_avail (o_credit_avail),
        .o_credit_err   (o_credit_err),
        .o_fsm_state    (o_fsm_state)
    );

    int           n_vec  = 0;
    int           n_miss = 0;
    logic [W-1:0] exp_q[$];
    int           model_credit [W];
    logic         model_err = 1'b0;
    logic [W-1:0] drop_pending = '0;
    bit           auto_drop = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard and credit model, sampled on the falling edge
    always @(negedge clk_320M) begin
        logic [W-1:0] avail_exp;
        avail_exp = '0;
        if (!rst) begin
            for (int k = 0; k < W; k++) avail_exp[k] = (model_credit[k] != 0);
            check("credit_avail", 32'(o_credit_avail), 32'(avail_exp));
            check("credit_err", 32'(o_credit_err), 32'(model_err));
            check("sel_onehot0", 32'($onehot0(o_common_sel)), 32'd1);
            check("grant_onehot0", 32'($onehot0(o_grant)), 32'd1);
            if (o_grant != '0) begin
                if (exp_q.size() == 0) check("grant_unexpected", 32'(o_grant), 32'd0);
                else                   check("grant_order", 32'(o_grant), 32'(exp_q.pop_front()));
            end
        end
        if (rst || clr_320M) begin
            for (int k = 0; k < W; k++) model_credit[k] = 1 << AWIDTH;
            model_err = 1'b0;
        end else begin
            for (int k = 0; k < W; k++) begin
                if (o_grant[k] && !i_buf_free[k]) model_credit[k]--;
                else if (!o_grant[k] && i_buf_free[k]) begin
                    if (model_credit[k] == (1 << AWIDTH)) model_err = 1'b1;
                    else                                  model_credit[k]++;
                end
            end
        end
    end

    // driver tasks: inputs change 1 ns after the rising edge, checks happen on the falling edge
    task automatic next_cycle();
        @(posedge clk_320M);
        #1;
        i_req        = i_req & ~drop_pending;
        drop_pending = '0;
        i_buf_free   = '0;
    endtask

    task automatic sample();
        @(negedge clk_320M);
        if (auto_drop) drop_pending = drop_pending | o_grant;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        clr_320M     = 1'b0;
        i_req        = '0;
        i_buf_free   = '0;
        drop_pending = '0;
        repeat (2) @(negedge clk_320M);
        next_cycle();
        rst = 1'b0;
        sample();
    endtask

    task automatic pulse_clr();
        next_cycle();
        clr_320M = 1'b1;
        sample();
        next_cycle();
        clr_320M = 1'b0;
        sample();
    endtask

    initial begin
        int sop_n;
        int gaps;
        int g;
        int sop_cyc [4];

        // single request
        do_reset();
        check("rst_state", 32'(o_fsm_state), 32'(IDLE));
        check("rst_avail", 32'(o_credit_avail), 32'hf);
        auto_drop = 1'b1;
        next_cycle();
        i_req = 4'b0001;
        exp_q.push_back(4'b0001);
        sample();
        check("t1_idle_sel", 32'(o_common_sel), 32'd0);
        next_cycle(); sample();
        check("t1_grant", 32'(o_grant), 32'h1);
        check("t1_sop", 32'(o_sop), 32'd1);
        check("t1_sel", 32'(o_common_sel), 32'h1);
        check("t1_id", 32'(o_grant_id), 32'd0);
        check("t1_state", 32'(o_fsm_state), 32'(XFER));
        for (int b = 1; b <= 3; b++) begin
            next_cycle(); sample();
            check("t1_sel_beat", 32'(o_common_sel), 32'h1);
            check("t1_sop_low", 32'(o_sop), 32'd0);
            check("t1_eop", 32'(o_eop), 32'(b == 3));
        end
        next_cycle(); sample();
        check("t1_sel_off", 32'(o_common_sel), 32'd0);
        check("t1_eop_off", 32'(o_eop), 32'd0);
        check("t1_state_idle", 32'(o_fsm_state), 32'(IDLE));
        // credit[0] is 127: the first return fills it, the second overflows
        next_cycle(); i_buf_free = 4'b0001; sample();
        next_cycle(); sample();
        check("t1_err_fill", 32'(o_credit_err), 32'd0);
        next_cycle(); i_buf_free = 4'b0001; sample();
        next_cycle(); sample();
        check("t1_err_over", 32'(o_credit_err), 32'd1);
        pulse_clr();
        check("t1_err_clr", 32'(o_credit_err), 32'd0);

        // all request, back-to-back
        do_reset();
        auto_drop = 1'b1;
        next_cycle();
        i_req = 4'hf;
        for (int i = 0; i < W; i++) exp_q.push_back(4'(1 << i));
        sample();
        sop_n = 0;
        gaps  = 0;
        for (int i = 0; i < 4; i++) sop_cyc[i] = 0;
        for (int c = 1; c <= 17; c++) begin
            next_cycle(); sample();
            if (o_sop) begin
                if (sop_n < 4) begin
                    sop_cyc[sop_n] = c;
                    check("t2_id", 32'(o_grant_id), 32'(sop_n));
                end
                sop_n++;
            end
            if (c <= 16 && o_common_sel == '0) gaps++;
        end
        check("t2_sop_count", 32'(sop_n), 32'd4);
        for (int i = 0; i < 4; i++) check("t2_sop_cycle", 32'(sop_cyc[i]), 32'(1 + 4*i));
        check("t2_gap", 32'(gaps), 32'd0);
        check("t2_idle_after", 32'(o_common_sel), 32'd0);

        // credit exhaustion on port 2
        do_reset();
        auto_drop = 1'b0;
        next_cycle();
        i_req = 4'b0100;
        for (int i = 0; i < (1 << AWIDTH); i++) exp_q.push_back(4'b0100);
        sample();
        g = 0;
        for (int c = 0; c < 540; c++) begin
            next_cycle(); sample();
            if (o_grant[2]) g++;
        end
        check("t3_grants", 32'(g), 32'd128);
        check("t3_avail2", 32'(o_credit_avail[2]), 32'd0);
        check("t3_sel_idle", 32'(o_common_sel), 32'd0);
        for (int c = 0; c < 20; c++) begin
            next_cycle(); sample();
            if (o_grant[2]) g++;
        end
        check("t3_no_more", 32'(g), 32'd128);
        next_cycle();
        i_buf_free = 4'b0100;
        exp_q.push_back(4'b0100);
        sample();
        for (int c = 0; c < 10; c++) begin
            next_cycle(); sample();
            if (o_grant[2]) g++;
        end
        check("t3_one_more", 32'(g), 32'd129);
        i_req = '0;
        repeat (4) begin next_cycle(); sample(); end

        // simultaneous consume and return on port 1
        do_reset();
        auto_drop = 1'b1;
        next_cycle();
        i_req = 4'b0010;
        exp_q.push_back(4'b0010);
        sample();
        next_cycle();
        i_buf_free = 4'b0010;
        sample();
        check("t4_grant", 32'(o_grant), 32'h2);
        repeat (4) begin next_cycle(); sample(); end
        next_cycle(); i_buf_free = 4'b0010; sample();
        next_cycle(); sample();
        check("t4_still_full", 32'(o_credit_err), 32'd1);
        pulse_clr();
        check("t4_err_clr", 32'(o_credit_err), 32'd0);

        // overflow on port 3
        next_cycle(); i_buf_free = 4'b1000; sample();
        for (int c = 0; c < 5; c++) begin
            next_cycle(); sample();
            check("t5_err_sticky", 32'(o_credit_err), 32'd1);
        end
        check("t5_avail3", 32'(o_credit_avail[3]), 32'd1);
        pulse_clr();
        check("t5_err_clr", 32'(o_credit_err), 32'd0);
        next_cycle(); i_buf_free = 4'b1000; sample();
        next_cycle(); sample();
        check("t5_err_again", 32'(o_credit_err), 32'd1);
        pulse_clr();

        // reset in the middle of a cell
        auto_drop = 1'b1;
        next_cycle();
        i_req = 4'b0001;
        exp_q.push_back(4'b0001);
        sample();
        next_cycle(); sample();
        next_cycle(); sample();
        next_cycle(); sample();
        check("t6_beat2_sel", 32'(o_common_sel), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_sel_abort", 32'(o_common_sel), 32'd0);
        check("t6_eop_abort", 32'(o_eop), 32'd0);
        check("t6_state_abort", 32'(o_fsm_state), 32'(IDLE));
        i_req = '0;
        next_cycle(); sample();
        next_cycle();
        rst = 1'b0;
        sample();
        next_cycle(); i_buf_free = 4'b0001; sample();
        next_cycle(); sample();
        check("t6_credit0_full", 32'(o_credit_err), 32'd1);
        pulse_clr();
        next_cycle();
        i_req = 4'b0011;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        sample();
        next_cycle(); sample();
        check("t6_ptr_zero", 32'(o_grant), 32'h1);
        repeat (10) begin next_cycle(); sample(); end

        // final report
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gsm_bus_sched.md
Name: gsm_bus_sched

Overview:
- Scheduler for the 320 MHz common write bus into the grouped-share-memory unit.
- Arbitrates MWIDTH ingress requesters round-robin and holds each grant for one full cell of CELL_BEATS beats.
- Drives the one-hot common-bus select.
- Keeps a per-port credit count of that port's private cell region: a grant consumes one credit; a buffer-free return restores one.

Parameters:
MWIDTH, 4, number of ingress ports / requesters
LOG_MWIDTH, 2, log2(MWIDTH)
AWIDTH, 7, per-port cell address width; credits per port = 2**AWIDTH
CELL_BEATS, 4, bus beats per cell (>=1)
LOG_BEATS, 2, beat counter width (2**LOG_BEATS >= CELL_BEATS)

Ports:
clk_320M  in  1  bus clock; only clock
rst  in  1  asynchronous active-high reset
clr_320M  in  1  synchronous clear, same effect as rst
i_req  in  MWIDTH  per-port cell-ready request, level; held until granted
i_buf_free  in  MWIDTH  per-port credit return pulse, one credit per cycle per port
o_grant  out  MWIDTH  one-hot, one-cycle pulse on the first beat of a granted cell
o_common_sel  out  MWIDTH  one-hot bus select, asserted for all CELL_BEATS beats of a cell
o_sop  out  1  first beat of cell
o_eop  out  1  last beat of cell
o_grant_id  out  LOG_MWIDTH  encoded owner of current cell; valid while o_common_sel != 0
o_credit_avail  out  MWIDTH  credit[k] != 0
o_credit_err  out  1  sticky: credit returned to a full counter

Behaviour:
- Clock/reset: one clock (clk_320M); reset is asynchronous and active-high (rst).
- Reset / clr_320M values:
  - FSM = IDLE; all outputs 0 except o_credit_avail = all ones.
  - Priority pointer = 0; beat counter = 0.
  - Each credit[k] = 2**AWIDTH, width AWIDTH+1.
  - A reset or clear asserted mid-cell aborts the cell immediately; no o_eop is issued.
- Eligibility: elig[k] = i_req[k] & (credit[k] != 0).
- Arbitration:
  - Round-robin starting from the pointer; the first eligible port at or after the pointer (mod MWIDTH) wins.
  - After granting port k, pointer = (k+1) mod MWIDTH.
- FSM IDLE:
  - Evaluates every cycle.
  - If any port is eligible, it registers the winner: on the next cycle o_common_sel = onehot(k), o_grant = onehot(k), o_sop = 1, beat = 0, state goes to XFER.
  - Latency is request to first beat = 1 cycle.
- FSM XFER:
  - o_common_sel is held constant; beat increments each cycle.
  - o_eop = 1 when beat == CELL_BEATS-1. If CELL_BEATS = 1, o_sop and o_eop are both 1 on the same cycle.
  - On the last beat the arbiter evaluates again, with the pointer already advanced:
    - if a port is eligible, the next cell starts on the immediately following cycle (zero bubble: new o_grant/o_sop, beat = 0);
    - otherwise o_common_sel = 0 next cycle and the FSM returns to IDLE.
- Request rules:
  - A requester deasserts i_req in the cycle after it sees its o_grant.
  - i_req deasserting mid-cell does not shorten the cell.
  - The owning port's own i_req is not eligible while its cell is in progress, until o_eop.
- Credits:
  - credit[k] decrements on the o_grant[k] cycle.
  - credit[k] increments on i_buf_free[k].
  - Both in the same cycle leave the count unchanged.
  - A return while credit == 2**AWIDTH (and no simultaneous grant) saturates the count and sets o_credit_err until rst/clr.
  - A grant never occurs with credit 0.
- o_credit_avail is combinational from the credit registers.
- o_common_sel and o_grant are always one-hot or zero.

Decomposition:
- Package gsm_pkg:
  - constants MWIDTH, LOG_MWIDTH, AWIDTH, CELL_BEATS;
  - FSM state enum {IDLE, XFER};
  - function onehot_to_bin.
- One sub-module gsm_rr_arbiter: combinational round-robin pick from (elig, pointer) giving winner one-hot, winner id and any_valid. It is reusable by the egress side.
- Credit counters and FSM live in gsm_bus_sched.

Test Plan:
- Single request: after reset, i_req=0001 at cycle 5 -> o_grant=0001 and o_sop at cycle 6; o_common_sel=0001 for cycles 6-9; o_eop at 9; o_common_sel=0 at 10; credit[0]=127.
- All request: i_req=1111 held, each port dropping its request after its grant -> grant order 0,1,2,3 back-to-back; o_sop at cycles 1,5,9,13; no idle gap.
- Credit exhaustion: port 2 requests continuously with no i_buf_free -> exactly 128 grants, then o_credit_avail[2]=0 and no further grant. One i_buf_free[2] pulse -> one more grant.
- Simultaneous consume/return: i_buf_free[1] pulsed on the o_grant[1] cycle -> credit[1] unchanged.
- Overflow: i_buf_free[3] pulsed at full credit -> o_credit_err=1 and stays 1; credit[3] stays 128; clr_320M clears the flag.
- Mid-cell reset: rst asserted on beat 2 -> o_common_sel=0 and o_eop=0 at once; after release, credits are back to 128 and the pointer is 0.
